// File: rtl/instruction_loader_pkg.sv
// -----------------------------------------------------------------------------
// instruction_loader_pkg
// Shared definitions for the instruction loader: loader FSM state encoding,
// the end-of-program marker and the word / byte widths used by the pipeline.
// -----------------------------------------------------------------------------
package instruction_loader_pkg;

    localparam int NB_DATA_C = 32;
    localparam int NB_BYTE_C = 8;

    // End-of-program marker; the loader stores it and then stops.
    localparam logic [NB_DATA_C-1:0] HALT_WORD_C = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage : instruction_loader_pkg

// File: rtl/instruction_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// instruction_loader_word_assembler
// Packs a stream of bytes into big-endian words: the first byte of a word ends
// up in the most significant byte. After the last byte of a word the word is
// presented on 'word' together with a one-cycle 'word_ready' pulse.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        drop any partial word and restart at byte 0 (wins over valid)
//   byte_valid   byte_data holds a new byte
//   byte_data    incoming byte
//   word_ready   one-cycle pulse: 'word' holds a complete word
//   word         assembled word (shift register contents)
// -----------------------------------------------------------------------------
module instruction_loader_word_assembler
    import instruction_loader_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_C,
    parameter int NB_BYTE = NB_BYTE_C
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               byte_valid,
    input  logic [NB_BYTE-1:0] byte_data,
    output logic               word_ready,
    output logic [NB_DATA-1:0] word
);

    logic [1:0]         byte_cnt_r;
    logic [NB_DATA-1:0] shift_r;
    logic               word_ready_r;

    // Byte counter, shift register and word-complete pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_r   <= 2'd0;
            shift_r      <= {NB_DATA{1'b0}};
            word_ready_r <= 1'b0;
        end else if (clear) begin
            byte_cnt_r   <= 2'd0;
            shift_r      <= {NB_DATA{1'b0}};
            word_ready_r <= 1'b0;
        end else if (byte_valid) begin
            byte_cnt_r   <= byte_cnt_r + 2'd1;
            shift_r      <= {shift_r[NB_DATA-NB_BYTE-1:0], byte_data};
            word_ready_r <= (byte_cnt_r == 2'd3);
        end else begin
            word_ready_r <= 1'b0;
        end
    end

    assign word_ready = word_ready_r;
    assign word       = shift_r;

endmodule : instruction_loader_word_assembler

// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
// Fills instruction memory from the debug UART byte stream. Bytes are packed
// into big-endian 32-bit words, each word is written at an incrementing word
// address, and loading stops after the HALT word is stored or after the last
// memory location has been written (overflow).
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start          begin / restart a load (honoured in IDLE and DONE only)
//   i_rx_valid       i_rx_data holds a new byte
//   i_rx_data        received byte
//   o_mem_we         instruction-memory write enable (one cycle per word)
//   o_mem_addr       word write address
//   o_mem_wdata      word to write
//   o_busy           load in progress
//   o_done           load finished, held until the next start
//   o_overflow       load ended because memory filled up, not by HALT
//   o_word_count     words written in the current / last load
// -----------------------------------------------------------------------------
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int               NB_DATA   = NB_DATA_C,
    parameter int               NB_BYTE   = NB_BYTE_C,
    parameter int               NB_ADDR   = 8,
    parameter logic [NB_DATA-1:0] HALT_WORD = HALT_WORD_C
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_rx_valid,
    input  logic [NB_BYTE-1:0] i_rx_data,
    output logic               o_mem_we,
    output logic [NB_ADDR-1:0] o_mem_addr,
    output logic [NB_DATA-1:0] o_mem_wdata,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_overflow,
    output logic [NB_ADDR:0]   o_word_count
);

    state_t             state_r;
    logic               mem_we_r;
    logic [NB_ADDR-1:0] mem_addr_r;
    logic [NB_DATA-1:0] mem_wdata_r;
    logic               busy_r;
    logic               done_r;
    logic               overflow_r;
    logic [NB_ADDR:0]   word_count_r;

    logic               start_s;
    logic               halt_s;
    logic               last_addr_s;
    logic               terminate_s;
    logic               asm_clear_s;
    logic               asm_valid_s;
    logic               word_ready_s;
    logic [NB_DATA-1:0] word_s;

    // Decode of start acceptance, load termination and assembler control.
    always_comb begin
        start_s     = 1'b0;
        asm_valid_s = 1'b0;
        halt_s      = (mem_wdata_r == HALT_WORD);
        last_addr_s = (mem_addr_r == {NB_ADDR{1'b1}});
        terminate_s = (state_r == ST_WRITE) && (halt_s || last_addr_s);
        if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
            start_s = i_start;
        end else begin
            // Bytes are accepted in WRITE too, so a back-to-back stream loses nothing.
            asm_valid_s = i_rx_valid;
        end
        // A byte taken during the terminating WRITE is discarded here.
        asm_clear_s = start_s || terminate_s;
    end

    instruction_loader_word_assembler #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_word_assembler (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .clear      (asm_clear_s),
        .byte_valid (asm_valid_s),
        .byte_data  (i_rx_data),
        .word_ready (word_ready_s),
        .word       (word_s)
    );

    // Loader FSM with address / word counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= ST_IDLE;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {NB_ADDR{1'b0}};
            mem_wdata_r  <= {NB_DATA{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            overflow_r   <= 1'b0;
            word_count_r <= {(NB_ADDR+1){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    mem_we_r <= 1'b0;
                    if (start_s) begin
                        state_r      <= ST_LOAD;
                        mem_addr_r   <= {NB_ADDR{1'b0}};
                        busy_r       <= 1'b1;
                        done_r       <= 1'b0;
                        overflow_r   <= 1'b0;
                        word_count_r <= {(NB_ADDR+1){1'b0}};
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_LOAD: begin
                    if (word_ready_s) begin
                        state_r     <= ST_WRITE;
                        mem_we_r    <= 1'b1;
                        mem_wdata_r <= word_s;
                    end else begin
                        mem_we_r <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    mem_we_r     <= 1'b0;
                    word_count_r <= word_count_r + (NB_ADDR+1)'(1);
                    if (terminate_s) begin
                        // HALT has priority: a HALT in the last slot is not an overflow.
                        state_r    <= ST_DONE;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        overflow_r <= !halt_s;
                    end else begin
                        state_r    <= ST_LOAD;
                        mem_addr_r <= mem_addr_r + NB_ADDR'(1);
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    mem_we_r <= 1'b0;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_we     = mem_we_r;
    assign o_mem_addr   = mem_addr_r;
    assign o_mem_wdata  = mem_wdata_r;
    assign o_busy       = busy_r;
    assign o_done       = done_r;
    assign o_overflow   = overflow_r;
    assign o_word_count = word_count_r;

endmodule : instruction_loader

// File: tb/tb_instruction_loader.sv
// -----------------------------------------------------------------------------
// tb_instruction_loader
// Self-checking bench for instruction_loader with a 4-word memory (NB_ADDR=2).
// A table of programs with their expected results, hand-written timing and
// reset sequences, and random programs scored against a program-level model.
// -----------------------------------------------------------------------------
module tb_instruction_loader;

    localparam int          NB_ADDR = 2;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] HALT    = 32'hFFFF_FFFF;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic                 o_mem_we;
    logic [NB_ADDR-1:0]   o_mem_addr;
    logic [31:0]          o_mem_wdata;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_overflow;
    logic [NB_ADDR:0]     o_word_count;

    instruction_loader #(.NB_ADDR(NB_ADDR)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_rx_valid   (rx_valid),
        .i_rx_data    (rx_data),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_overflow   (o_overflow),
        .o_word_count (o_word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NB_ADDR-1:0] a;
        logic [31:0]        d;
    } wr_t;

    // Write monitor: logs every memory write and counts multi-cycle enables.
    wr_t wr_q[$];
    int  we_pairs = 0;
    logic prev_we = 1'b0;
    always @(negedge clk) begin
        prev_we <= o_mem_we;
        if (o_mem_we && prev_we) we_pairs <= we_pairs + 1;
        if (o_mem_we) wr_q.push_back({o_mem_addr, o_mem_wdata});
    end

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Program to send and expected outcome.
    logic [31:0]        stim_w[8];
    int                 stim_n;
    logic [31:0]        exp_w[8];
    logic [NB_ADDR-1:0] exp_a[8];
    int                 exp_n;
    logic               exp_ovf;
    int                 exp_cnt;

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!o_done && k < 40) begin @(posedge clk); #1; k++; end
        chk({tag, "_done"}, {63'd0, o_done}, 64'd1);
    endtask

    // gap < 0 selects a random 0..2 idle cycles after each byte.
    task automatic drive_load(input string tag, input int gap);
        int base = wr_q.size();
        int pairs0 = we_pairs;
        pulse_start();
        for (int i = 0; i < stim_n; i++)
            for (int b = 0; b < 4; b++)
                send_byte(stim_w[i][31-8*b -: 8], (gap < 0) ? $urandom_range(0, 2) : gap);
        wait_done(tag);
        repeat (2) begin @(posedge clk); #1; end
        chk({tag, "_nwr"}, 64'(wr_q.size() - base), 64'(exp_n));
        for (int i = 0; i < exp_n; i++)
            if (base + i < wr_q.size())
                chk({tag, "_wr"}, 64'({wr_q[base+i].a, wr_q[base+i].d}), 64'({exp_a[i], exp_w[i]}));
        chk({tag, "_ovf"}, {63'd0, o_overflow}, {63'd0, exp_ovf});
        chk({tag, "_cnt"}, 64'(o_word_count), 64'(exp_cnt));
        chk({tag, "_busy"}, {63'd0, o_busy}, 64'd0);
        chk({tag, "_we_width"}, 64'(we_pairs - pairs0), 64'd0);
    endtask

    // Program-level reference: store words in order until HALT or memory end.
    task automatic model();
        exp_n   = 0;
        exp_ovf = 1'b0;
        for (int i = 0; i < stim_n; i++) begin
            exp_a[exp_n] = NB_ADDR'(exp_n);
            exp_w[exp_n] = stim_w[i];
            exp_n++;
            if (stim_w[i] == HALT) break;
            if (exp_n == DEPTH) begin exp_ovf = 1'b1; break; end
        end
        exp_cnt = exp_n;
    endtask

    typedef struct packed {
        logic [4*32-1:0] words;   // word 0 in the top bits
        int              n;
        int              gap;
        int              exp_n;
        logic            exp_ovf;
        int              exp_cnt;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int base;
        logic [31:0] w;

        vecs[0] = '{{32'h2008_0005, 32'h30A5_00FF, HALT, 32'h0}, 3, 1, 3, 1'b0, 3};
        vecs[1] = '{{32'h2008_0005, 32'h30A5_00FF, HALT, 32'h0}, 3, 0, 3, 1'b0, 3};
        vecs[2] = '{{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444}, 4, 0, 4, 1'b1, 4};
        vecs[3] = '{{HALT, 32'h0, 32'h0, 32'h0}, 1, 0, 1, 1'b0, 1};
        vecs[4] = '{{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, HALT}, 4, 2, 4, 1'b0, 4};

        rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({o_mem_we, o_mem_addr, o_mem_wdata, o_busy, o_done, o_overflow, o_word_count}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven programs; afterwards stray bytes in DONE must not write.
        for (int v = 0; v < 5; v++) begin
            stim_n = vecs[v].n;
            for (int i = 0; i < 4; i++) stim_w[i] = vecs[v].words[127-32*i -: 32];
            exp_n   = vecs[v].exp_n;
            exp_ovf = vecs[v].exp_ovf;
            exp_cnt = vecs[v].exp_cnt;
            for (int i = 0; i < exp_n; i++) begin
                exp_a[i] = NB_ADDR'(i);
                exp_w[i] = stim_w[i];
            end
            drive_load($sformatf("vec%0d", v), vecs[v].gap);
            base = wr_q.size();
            for (int b = 0; b < 6; b++) send_byte(8'h5A + 8'(b), 0);
            repeat (3) begin @(posedge clk); #1; end
            chk($sformatf("vec%0d_done_ignores_bytes", v), 64'(wr_q.size() - base), 64'd0);
        end

        // Exact write / done timing, and start in LOAD does not reset the address.
        pulse_start();
        chk("busy_after_start", {63'd0, o_busy}, 64'd1);
        rx_valid = 1'b1;
        rx_data = 8'hDE; @(posedge clk); #1;
        rx_data = 8'hAD; @(posedge clk); #1;
        rx_data = 8'hBE; @(posedge clk); #1;
        rx_data = 8'hEF; @(posedge clk); #1;
        rx_valid = 1'b0;
        chk("we_not_yet", {63'd0, o_mem_we}, 64'd0);
        @(posedge clk); #1;
        chk("we_word0", 64'({o_mem_we, o_mem_addr, o_mem_wdata}), 64'({1'b1, 2'd0, 32'hDEAD_BEEF}));
        @(posedge clk); #1;
        chk("we_end_addr_inc", 64'({o_mem_we, o_mem_addr}), 64'({1'b0, 2'd1}));
        pulse_start();
        for (int b = 0; b < 4; b++) send_byte(8'hFF, 0);
        @(posedge clk); #1;
        chk("halt_write", 64'({o_mem_we, o_mem_addr, o_mem_wdata, o_done}), 64'({1'b1, 2'd1, HALT, 1'b0}));
        @(posedge clk); #1;
        chk("done_after_halt", 64'({o_done, o_busy, o_overflow, o_word_count}), 64'({1'b1, 1'b0, 1'b0, 3'd2}));

        // Reset in the middle of a word, bytes while IDLE, then a clean load.
        pulse_start();
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", 64'({o_mem_we, o_mem_addr, o_mem_wdata, o_busy, o_done, o_overflow, o_word_count}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        base = wr_q.size();
        for (int b = 0; b < 4; b++) send_byte(8'h12, 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("idle_ignores_bytes", 64'({o_busy, 32'(wr_q.size() - base)}), 64'd0);
        stim_n = 1;
        stim_w[0] = HALT;
        model();
        drive_load("after_reset", 0);

        // Random programs against the program-level model.
        for (int it = 0; it < 30; it++) begin
            stim_n = $urandom_range(1, 6);
            for (int i = 0; i < stim_n; i++) begin
                w = $urandom;
                stim_w[i] = ($urandom_range(0, 3) == 0) ? HALT : w;
            end
            if (stim_n < DEPTH) stim_w[stim_n-1] = HALT;
            model();
            drive_load($sformatf("rand%0d", it), -1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_instruction_loader
